// File: rtl/nios_v1_stream_ram_writer_if.sv
// rtl/nios_v1_stream_ram_writer_if.sv - stream sink and on-chip memory write port bundle
interface nios_v1_stream_ram_writer_if;
    logic        snk_valid;
    logic        snk_ready;
    logic [31:0] snk_data;
    logic        snk_sop;
    logic        snk_eop;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;

    modport master (
        output snk_valid, snk_data, snk_sop, snk_eop,
        input  snk_ready,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
    );

    modport slave (
        input  snk_valid, snk_data, snk_sop, snk_eop,
        output snk_ready,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
    );
endinterface

// File: rtl/nios_v1_stream_ram_writer.sv
// rtl/nios_v1_stream_ram_writer.sv - captures one stream packet into on-chip memory
// Define STREAM_RAM_WRITER_WRAP_EN to wrap the write pointer instead of stopping when full.
module nios_v1_stream_ram_writer #(
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 5120
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          stop,
    nios_v1_stream_ram_writer_if.slave    bus,
    output logic [12:0]                   words_written,
    output logic                          busy,
    output logic                          done,
    output logic                          truncated
);

    localparam logic [12:0] BASE_A   = 13'(BASE_ADDR);
    localparam logic [12:0] DEPTH_W  = 13'(DEPTH);
    localparam logic [12:0] LAST_PTR = 13'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t      state;
    logic [12:0] wr_ptr;
    logic        accept;
    logic        store;
    logic        at_last;
    logic        fill_end;
    logic        finish;

    assign bus.mem_clken = 1'b1;

    // snk_ready is only ever high in ARMED/CAPTURE, so accept already implies one of them.
    always_comb begin
        accept  = bus.snk_valid && bus.snk_ready;
        store   = accept && ((state == CAPTURE) || (state == ARMED && bus.snk_sop));
        at_last = (wr_ptr == LAST_PTR);
`ifdef STREAM_RAM_WRITER_WRAP_EN
        fill_end = 1'b0;
`else
        fill_end = at_last;
`endif
        finish  = store && (bus.snk_eop || fill_end);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            wr_ptr             <= '0;
            words_written      <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            truncated          <= 1'b0;
            bus.snk_ready      <= 1'b0;
            bus.mem_chipselect <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_writedata  <= '0;
            bus.mem_byteenable <= '0;
        end else begin
            bus.mem_chipselect <= store;
            bus.mem_write      <= store;
            bus.mem_byteenable <= store ? 4'hF : 4'h0;
            if (store) begin
                bus.mem_address   <= BASE_A + wr_ptr;
                bus.mem_writedata <= bus.snk_data;
            end
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state         <= ARMED;
                        bus.snk_ready <= 1'b1;
                        busy          <= 1'b1;
                        wr_ptr        <= '0;
                        words_written <= '0;
                        truncated     <= 1'b0;
                    end
                end
                ARMED, CAPTURE: begin
                    if (store) begin
                        words_written <= (words_written == DEPTH_W) ? DEPTH_W
                                                                    : words_written + 13'd1;
                        // An eop landing on the last slot is a complete packet, not a truncation.
                        if (at_last && !bus.snk_eop)
                            truncated <= 1'b1;
`ifdef STREAM_RAM_WRITER_WRAP_EN
                        wr_ptr <= at_last ? 13'd0 : wr_ptr + 13'd1;
`else
                        wr_ptr <= wr_ptr + 13'd1;
`endif
                    end
                    if (stop || finish) begin
                        state         <= DONE;
                        bus.snk_ready <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                    end else if (store) begin
                        state <= CAPTURE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    bus.snk_ready <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/nios_v1_stream_ram_writer.md
NIOS_V1_STREAM_RAM_WRITER -- requirements
Module: nios_v1_stream_ram_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 0: first on-chip memory word address written.
REQ-002 SHALL have parameter DEPTH, default 5120: capture window size in 32-bit words; BASE_ADDR+DEPTH <= 5120.
REQ-003 SHALL have port clk  in  1: single clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1: one-cycle pulse that arms a capture.
REQ-006 SHALL have port stop  in  1: one-cycle pulse that aborts a capture.
REQ-007 SHALL have port snk_valid / snk_ready  in / out  1 / 1: stream handshake; a beat transfers when both are high.
REQ-008 SHALL have port snk_data  in  32: stream word.
REQ-009 SHALL have port snk_sop / snk_eop  in  1 / 1: packet start and end markers.
REQ-010 SHALL have ports mem_address (out, 13), mem_byteenable (out, 4), mem_chipselect (out, 1), mem_write (out, 1), mem_writedata (out, 32), mem_clken (out, 1): on-chip memory write port.
REQ-011 SHALL have port words_written  out  13: words stored in the current or last capture.
REQ-012 SHALL have ports busy (out, 1), done (out, 1), truncated (out, 1): status outputs.

Function
REQ-013 SHALL implement FSM states IDLE, ARMED, CAPTURE, DONE.
REQ-014 IDLE: on start go to ARMED; clear words_written, truncated, and write pointer.
REQ-015 ARMED: snk_ready=1; beats without snk_sop are accepted and discarded; a beat with snk_sop is stored and the FSM goes to CAPTURE.
REQ-016 CAPTURE: snk_ready=1; every accepted beat is stored; an accepted beat with snk_eop goes to DONE.
REQ-017 A beat with sop and eop together in ARMED is a one-word packet: stored, then DONE.
REQ-018 DONE: snk_ready=0; done is a one-cycle pulse on entry; the next state is IDLE.
REQ-019 busy SHALL be 1 in ARMED and CAPTURE, else 0; snk_ready SHALL be 0 in IDLE and DONE.
REQ-020 Write latency: a beat accepted in cycle N drives mem_chipselect=mem_write=1 for exactly cycle N+1.
REQ-021 In that cycle: mem_address=BASE_ADDR+wr_ptr, mem_writedata=beat data, mem_byteenable=4'hF; all memory outputs are registered.
REQ-022 mem_clken SHALL be constant 1; the memory never back-pressures, so one write per cycle is sustained.
REQ-023 wr_ptr and words_written increment by 1 per stored beat; words_written saturates at DEPTH.
REQ-024 stop in ARMED or CAPTURE goes to DONE next cycle; a write already registered from cycle N is still issued in N+1.
REQ-025 stop and start in the same cycle: stop wins and start is ignored.
REQ-026 start outside IDLE is ignored.
REQ-027 Full, wrap disabled: storing word DEPTH-1 without eop sets truncated=1 and goes to DONE.
REQ-028 Truncation on an eop beat: a beat carrying eop as word DEPTH-1 goes to DONE with truncated=0.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, with wr_ptr=0 and words_written=0.
REQ-030 reset_n low SHALL asynchronously force all status outputs low: busy=0, done=0, truncated=0.
REQ-031 reset_n low SHALL asynchronously force the memory and stream outputs: mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=0, snk_ready=0.
REQ-032 Reset mid-capture SHALL cancel any pending write; no memory write occurs in the cycle after reset deasserts.

Configuration
REQ-033 Macro STREAM_RAM_WRITER_WRAP_EN SHALL control wrap behaviour; without it, behaviour is REQ-027.
REQ-034 With STREAM_RAM_WRITER_WRAP_EN defined, a pointer of DEPTH-1 SHALL wrap to 0 and capture continues until eop or stop.
REQ-035 With STREAM_RAM_WRITER_WRAP_EN defined, truncated SHALL be set on the first wrap.
REQ-036 With STREAM_RAM_WRITER_WRAP_EN defined, words_written SHALL hold DEPTH once saturated.

Verification
REQ-037 Basic packet: start; 4 beats 0x11..0x44, sop on first, eop on last -> writes to addr 0..3 one cycle after each beat; done pulse; words_written=4; truncated=0.
REQ-038 Pre-sop discard: in ARMED, 3 beats without sop, then a sop packet of 2 -> only 2 writes, at addr 0 and 1.
REQ-039 Full window: DEPTH=8, no macro, 10-beat packet -> 8 writes (addr 0..7); truncated=1; snk_ready=0 after the 8th beat; words_written=8.
REQ-040 Wrap: DEPTH=8 with macro, 10-beat packet -> 9th and 10th beats written to addr 0 and 1; truncated=1; words_written=8.
REQ-041 Stop: stop in the same cycle as the 3rd accepted beat -> 3rd write still issued; DONE next cycle; words_written=3; start in the same cycle as stop is ignored.
REQ-042 Reset: reset_n low for 1 cycle mid-packet with BASE_ADDR=16 -> outputs zero immediately; no write after release; next start writes from addr 16.
